// File: rtl/psum_gb_writer.sv
// psum_gb_writer: round-robin arbitrates three psum channels and serializes each vector into GB write beats.
module psum_gb_writer #(
  parameter int PSUM_WIDTH = 32,
  parameter int NUM_LANE   = 16,
  parameter int GB_WIDTH   = 128,
  parameter int VEC_AW     = 6,
  localparam int VW        = NUM_LANE * PSUM_WIDTH,
  localparam int BEATS     = VW / GB_WIDTH,
  localparam int BW        = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 CfgClr,
  input  logic [VEC_AW:0]      CfgNumVec,
  input  logic                 PSUMGB_val0,
  input  logic [VW-1:0]        PSUMGB_data0,
  output logic                 GBPSUM_rdy0,
  input  logic                 PSUMGB_val1,
  input  logic [VW-1:0]        PSUMGB_data1,
  output logic                 GBPSUM_rdy1,
  input  logic                 PSUMGB_val2,
  input  logic [VW-1:0]        PSUMGB_data2,
  output logic                 GBPSUM_rdy2,
  output logic                 GB_wr_en,
  input  logic                 GB_wr_rdy,
  output logic [2+VEC_AW+BW-1:0] GB_wr_addr,
  output logic [GB_WIDTH-1:0]  GB_wr_data,
  output logic                 Done
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t            r_state, w_state_nxt;
  logic [BW-1:0]     r_beat;
  logic [1:0]        r_ch, r_ptr, w_gnt, w_p1, w_p2;
  logic [VEC_AW-1:0] r_vec;
  logic [VW-1:0]     r_hold;
  logic [VEC_AW:0]   r_cnt [3];
  logic [VEC_AW:0]   w_cnt_eff [3];
  logic [VW-1:0]     w_din [3];
  logic [2:0]        w_req, w_sat;
  logic              w_last, w_vec_done, w_arb, w_acc, r_done;

  assign w_din[0]   = PSUMGB_data0;
  assign w_din[1]   = PSUMGB_data1;
  assign w_din[2]   = PSUMGB_data2;
  assign w_last     = r_beat == BW'(BEATS - 1);
  assign w_vec_done = r_state == WRITE && w_last && GB_wr_rdy;
  // Saturation uses the count including a vector finishing this cycle, so a back-to-back grant cannot overshoot.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_cnt_eff[c] = r_cnt[c] + (VEC_AW+1)'(w_vec_done && r_ch == 2'(c));
      w_sat[c]     = w_cnt_eff[c] == CfgNumVec;
    end
  end
  assign w_req = {PSUMGB_val2, PSUMGB_val1, PSUMGB_val0} & ~w_sat;
  assign w_p1  = r_ptr == 2'd2 ? 2'd0 : r_ptr + 2'd1;
  assign w_p2  = r_ptr == 2'd0 ? 2'd2 : r_ptr - 2'd1;
  assign w_gnt = w_req[r_ptr] ? r_ptr : w_req[w_p1] ? w_p1 : w_p2;
  assign w_arb = !Reset && !CfgClr && (r_state == IDLE || w_vec_done);
  assign w_acc = w_arb && |w_req;

  assign GBPSUM_rdy0 = w_acc && w_gnt == 2'd0;
  assign GBPSUM_rdy1 = w_acc && w_gnt == 2'd1;
  assign GBPSUM_rdy2 = w_acc && w_gnt == 2'd2;
  assign GB_wr_en    = r_state == WRITE;
  assign GB_wr_data  = r_hold[r_beat*GB_WIDTH +: GB_WIDTH];
  assign GB_wr_addr  = {r_ch, r_vec, r_beat};
  assign Done        = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_acc ? WRITE : w_vec_done ? IDLE : r_state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_vec   <= '0;
      r_hold  <= '0;
      r_cnt   <= '{default: '0};
      r_done  <= 1'b0;
    end else if (CfgClr) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_vec   <= '0;
      r_hold  <= '0;
      r_cnt   <= '{default: '0};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WRITE && GB_wr_rdy) r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (w_vec_done) r_cnt[r_ch] <= w_cnt_eff[r_ch];
      if (w_acc) begin
        r_hold <= w_din[w_gnt];
        r_ch   <= w_gnt;
        r_vec  <= w_cnt_eff[w_gnt][VEC_AW-1:0];
        r_ptr  <= w_gnt == 2'd2 ? 2'd0 : w_gnt + 2'd1;
        r_beat <= '0;
      end
      r_done <= r_done | (&w_sat);
    end
  end
endmodule

// File: tb/tb_psum_gb_writer.sv
// tb_psum_gb_writer: randomized bench comparing the writer against a queue-based beat model.
module tb_psum_gb_writer;
  logic         Clk = 1'b0, Reset = 1'b1, CfgClr = 1'b0;
  logic [6:0]   CfgNumVec = 7'd64;
  logic         PSUMGB_val0 = 1'b0, PSUMGB_val1 = 1'b0, PSUMGB_val2 = 1'b0;
  logic         GBPSUM_rdy0, GBPSUM_rdy1, GBPSUM_rdy2;
  logic         GB_wr_en, GB_wr_rdy = 1'b0, Done;
  logic [9:0]   GB_wr_addr;
  logic [127:0] GB_wr_data;
  logic [511:0] dat [3];

  typedef struct {
    logic [9:0]   addr;
    logic [127:0] data;
    int           ch;
    bit           last;
  } beat_t;

  beat_t q[$];
  int    m_cnt[3];
  int    m_ptr;
  bit    m_done;
  bit    renew[3];
  int    n_chk = 0, n_err = 0;

  psum_gb_writer dut (
    .Clk(Clk), .Reset(Reset), .CfgClr(CfgClr), .CfgNumVec(CfgNumVec),
    .PSUMGB_val0(PSUMGB_val0), .PSUMGB_data0(dat[0]), .GBPSUM_rdy0(GBPSUM_rdy0),
    .PSUMGB_val1(PSUMGB_val1), .PSUMGB_data1(dat[1]), .GBPSUM_rdy1(GBPSUM_rdy1),
    .PSUMGB_val2(PSUMGB_val2), .PSUMGB_data2(dat[2]), .GBPSUM_rdy2(GBPSUM_rdy2),
    .GB_wr_en(GB_wr_en), .GB_wr_rdy(GB_wr_rdy), .GB_wr_addr(GB_wr_addr),
    .GB_wr_data(GB_wr_data), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] new_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int c = 0; c < 3; c++) m_cnt[c] = 0;
    m_ptr  = 0;
    m_done = 1'b0;
  endtask

  task automatic step(input logic [2:0] v, input logic wr, input logic clr, input int n);
    int    g;
    int    c;
    bit    all;
    beat_t b;
    @(negedge Clk);
    for (int k = 0; k < 3; k++) if (renew[k]) begin dat[k] = new_vec(); renew[k] = 1'b0; end
    {PSUMGB_val2, PSUMGB_val1, PSUMGB_val0} = v;
    GB_wr_rdy = wr;
    CfgClr    = clr;
    CfgNumVec = 7'(n);
    #1;
    check("wr_en", GB_wr_en, q.size() != 0);
    if (q.size() != 0) begin
      check("addr", GB_wr_addr, q[0].addr);
      check("data", GB_wr_data, q[0].data);
    end
    check("done", Done, m_done);
    if (q.size() != 0 && wr) begin
      b = q.pop_front();
      if (b.last) m_cnt[b.ch]++;
    end
    g = -1;
    if (q.size() == 0 && !clr)
      for (int k = 0; k < 3; k++) begin
        c = (m_ptr + k) % 3;
        if (g < 0 && v[c] && m_cnt[c] != n) g = c;
      end
    check("rdy", {GBPSUM_rdy2, GBPSUM_rdy1, GBPSUM_rdy0}, g < 0 ? 3'b000 : 3'b001 << g);
    if (g >= 0) begin
      for (int k = 0; k < 4; k++)
        q.push_back('{addr: {2'(g), 6'(m_cnt[g] % 64), 2'(k)}, data: dat[g][128*k +: 128], ch: g, last: k == 3});
      m_ptr    = (g + 1) % 3;
      renew[g] = 1'b1;
    end
    all = 1'b1;
    for (int k = 0; k < 3; k++) if (m_cnt[k] != n) all = 1'b0;
    m_done = m_done || all;
    if (clr) model_clear();
  endtask

  task automatic do_reset(input logic [2:0] v);
    @(negedge Clk);
    {PSUMGB_val2, PSUMGB_val1, PSUMGB_val0} = v;
    Reset = 1'b1;
    #1;
    check("rst_wr_en", GB_wr_en, 1'b0);
    check("rst_rdy", {GBPSUM_rdy2, GBPSUM_rdy1, GBPSUM_rdy0}, 3'b000);
    check("rst_done", Done, 1'b0);
    check("rst_addr", GB_wr_addr, 10'd0);
    check("rst_data", GB_wr_data, 128'd0);
    model_clear();
    @(negedge Clk);
    {PSUMGB_val2, PSUMGB_val1, PSUMGB_val0} = 3'b000;
    CfgClr = 1'b0;
    Reset  = 1'b0;
  endtask

  initial begin
    int n;
    for (int c = 0; c < 3; c++) begin dat[c] = new_vec(); renew[c] = 1'b0; end
    model_clear();
    do_reset(3'b111);
    for (int i = 0; i < 16; i++) dat[0][32*i +: 32] = 32'(i);
    step(3'b001, 1'b1, 1'b0, 64);
    repeat (6) step(3'b000, 1'b1, 1'b0, 64);
    do_reset(3'b000);
    repeat (30) step(3'b111, 1'b1, 1'b0, 64);
    repeat (4) step(3'b000, 1'b1, 1'b0, 64);
    step(3'b010, 1'b1, 1'b0, 64);
    step(3'b000, 1'b1, 1'b0, 64);
    step(3'b000, 1'b0, 1'b0, 64);
    step(3'b000, 1'b0, 1'b0, 64);
    step(3'b000, 1'b1, 1'b0, 64);
    step(3'b000, 1'b0, 1'b0, 64);
    repeat (3) step(3'b000, 1'b1, 1'b0, 64);
    step(3'b000, 1'b1, 1'b1, 2);
    repeat (40) step(3'b111, 1'b1, 1'b0, 2);
    check("done_final", Done, 1'b1);
    do_reset(3'b000);
    step(3'b001, 1'b1, 1'b0, 64);
    repeat (2) step(3'b000, 1'b1, 1'b0, 64);
    do_reset(3'b000);
    step(3'b001, 1'b1, 1'b0, 64);
    repeat (5) step(3'b000, 1'b1, 1'b0, 64);
    step(3'b001, 1'b1, 1'b1, 64);
    step(3'b001, 1'b1, 1'b0, 64);
    repeat (5) step(3'b000, 1'b1, 1'b0, 64);
    n = $urandom_range(1, 5);
    step(3'b000, 1'b1, 1'b1, n);
    repeat (1500) begin
      if ($urandom_range(0, 63) == 0) begin
        n = $urandom_range(1, 5);
        step(3'(($urandom)), 1'b1, 1'b1, n);
      end else
        step(3'(($urandom)), $urandom_range(0, 3) != 0, 1'b0, n);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
